// File: rtl/ext_intr_aggregator.sv
// External interrupt aggregator: synchronises raw sources, latches them as
// pending per line and drives a slice of the external interrupt vector.

package ext_intr_aggregator_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage

module ext_intr_aggregator
  import ext_intr_aggregator_pkg::*;
#(
  parameter int unsigned      N_SRC        = 4,
  parameter int unsigned      NEXT_INT     = 64,
  parameter int unsigned      INT_OFFSET   = 2,
  parameter int unsigned      SYNC_STAGES  = 2,
  parameter logic [N_SRC-1:0] RESET_ENABLE = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_SRC-1:0]    src_i,
  input  reg_req_t            reg_req_i,
  output reg_rsp_t            reg_rsp_o,
  output logic [NEXT_INT-1:0] intr_o,
  output logic                irq_any_o
);

  localparam int unsigned WW = SYNC_STAGES + 1;

  if (INT_OFFSET + N_SRC > NEXT_INT) begin : g_bad_cfg
    $error("INT_OFFSET+N_SRC exceeds NEXT_INT");
  end

  logic [N_SRC-1:0]    r_pend;
  logic [N_SRC-1:0]    r_en;
  logic [N_SRC-1:0]    r_mode;
  logic [N_SRC-1:0]    r_pol;
  logic [N_SRC-1:0]    r_hist;
  logic                r_cfg_wr;
  logic [WW-1:0]       r_warm;
  logic [NEXT_INT-1:0] r_intr;
  logic                r_any;

  logic [N_SRC-1:0]    w_sync;
  logic [N_SRC-1:0]    w_act;
  logic [N_SRC-1:0]    w_rise;
  logic [N_SRC-1:0]    w_set;
  logic [N_SRC-1:0]    w_clr;
  logic [N_SRC-1:0]    w_swset;
  logic [N_SRC-1:0]    w_pend_nxt;
  logic [N_SRC-1:0]    w_wmask;
  logic [N_SRC-1:0]    w_wd;
  logic [N_SRC-1:0]    w_rd;
  logic [NEXT_INT-1:0] w_intr_nxt;
  logic [2:0]          w_idx;
  logic                w_hit;
  logic                w_wr;
  logic                w_we_pend;
  logic                w_we_en;
  logic                w_we_mode;
  logic                w_we_pol;
  logic                w_we_sw;
  logic                w_unused;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign w_sync = src_i;
  end else begin : g_sync
    logic [N_SRC-1:0] r_sync [SYNC_STAGES];
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
      end else begin
        r_sync[0] <= src_i;
        for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      end
    end
    assign w_sync = r_sync[SYNC_STAGES-1];
  end

  assign w_hit = reg_req_i.valid
               && (reg_req_i.addr < 32'h18)
               && (reg_req_i.addr[1:0] == 2'b00);
  assign w_idx = reg_req_i.addr[4:2];
  assign w_wr  = w_hit && reg_req_i.write;
  assign w_wd  = reg_req_i.wdata[N_SRC-1:0];

  always_comb begin
    w_wmask = '0;
    for (int i = 0; i < N_SRC; i++) w_wmask[i] = reg_req_i.wstrb[i/8];
  end

  assign w_we_pend = w_wr && (w_idx == 3'd0);
  assign w_we_en   = w_wr && (w_idx == 3'd1);
  assign w_we_mode = w_wr && (w_idx == 3'd2);
  assign w_we_pol  = w_wr && (w_idx == 3'd3);
  assign w_we_sw   = w_wr && (w_idx == 3'd5);

  assign w_clr   = w_we_pend ? (w_wd & w_wmask) : '0;
  assign w_swset = w_we_sw   ? (w_wd & w_wmask) : '0;

  // Edges are ignored until the sync pipe has refilled after reset and for
  // the one cycle after a MODE/POLARITY write while hist catches up.
  assign w_act  = w_sync ^ r_pol;
  assign w_rise = w_act & ~r_hist
                & {N_SRC{r_warm[WW-1] & ~r_cfg_wr}};
  assign w_set  = (r_mode & w_rise) | (~r_mode & w_act) | w_swset;
  assign w_pend_nxt = w_set | (r_pend & ~w_clr);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pend   <= '0;
      r_en     <= RESET_ENABLE;
      r_mode   <= '0;
      r_pol    <= '0;
      r_hist   <= '0;
      r_cfg_wr <= 1'b0;
      r_warm   <= '0;
    end else begin
      r_pend   <= w_pend_nxt;
      r_hist   <= w_act;
      r_cfg_wr <= w_we_mode | w_we_pol;
      r_warm   <= (r_warm << 1) | WW'(1);
      if (w_we_en)
        r_en <= (r_en & ~w_wmask) | (w_wd & w_wmask);
      if (w_we_mode)
        r_mode <= (r_mode & ~w_wmask) | (w_wd & w_wmask);
      if (w_we_pol)
        r_pol <= (r_pol & ~w_wmask) | (w_wd & w_wmask);
    end
  end

  always_comb begin
    w_intr_nxt = '0;
    w_intr_nxt[INT_OFFSET +: N_SRC] = r_pend & r_en;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_intr <= '0;
      r_any  <= 1'b0;
    end else begin
      r_intr <= w_intr_nxt;
      r_any  <= |(r_pend & r_en);
    end
  end

  always_comb begin
    w_rd = '0;
    if (w_hit && !reg_req_i.write) begin
      unique case (w_idx)
        3'd0:    w_rd = r_pend;
        3'd1:    w_rd = r_en;
        3'd2:    w_rd = r_mode;
        3'd3:    w_rd = r_pol;
        3'd4:    w_rd = w_act;
        default: w_rd = '0;
      endcase
    end
  end

  assign reg_rsp_o.rdata = 32'(w_rd);
  assign reg_rsp_o.error = reg_req_i.valid && !w_hit;
  assign reg_rsp_o.ready = 1'b1;

  assign intr_o    = r_intr;
  assign irq_any_o = r_any;
  assign w_unused  = ^reg_req_i.wdata;

endmodule
